// File: rtl/simon_round_ctrl.sv
// -----------------------------------------------------------------------------
// simon_round_ctrl
// Control FSM for an iterative SIMON block cipher core. It sequences key
// loading and key-schedule expansion, then block loading, T cipher rounds and
// result hand-off. The datapath (state register and round-key slots) lives
// outside this block and follows the enables produced here.
//
// Ports
//   clk        rising-edge clock
//   nR         synchronous active-low reset
//   newKey     key words valid upstream (held until loadKey)
//   newData    block words valid upstream (held until loadData)
//   readOut    downstream has taken the result
//   loadKey    one-cycle acknowledge of newKey
//   loadData   one-cycle acknowledge of newData
//   initKey    copy the M key words into round-key slots 0..M-1
//   keyExpEn   compute the round key at slot count
//   initBlock  load blockIN into the state register
//   roundEn    apply round count to the state register
//   count      round / key-slot index
//   keyValid   a complete key schedule is present
//   doneData   result is valid in the state register
//   busy       FSM is not in IDLE
// -----------------------------------------------------------------------------
module simon_round_ctrl #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int Cb = 5
) (
  input  logic          clk,
  input  logic          nR,
  input  logic          newKey,
  input  logic          newData,
  input  logic          readOut,
  output logic          loadKey,
  output logic          loadData,
  output logic          initKey,
  output logic          keyExpEn,
  output logic          initBlock,
  output logic          roundEn,
  output logic [Cb-1:0] count,
  output logic          keyValid,
  output logic          doneData,
  output logic          busy
);

  // Reject parameter sets the counter or the key schedule cannot support.
  if (((2 ** Cb) < T) || (M >= T) || (M < 1) || (N < 1)) begin : g_bad_params
    $error("simon_round_ctrl: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEYLOAD = 3'd1,
    S_KEYEXP  = 3'd2,
    S_BLKLOAD = 3'd3,
    S_ROUND   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [Cb-1:0] CNT_LAST = Cb'(T - 1);
  localparam logic [Cb-1:0] CNT_KEY0 = Cb'(M);
  localparam logic [Cb-1:0] CNT_ONE  = Cb'(1);
  localparam logic [Cb-1:0] CNT_ZERO = Cb'(0);

  state_t        state_q, state_d;
  logic [Cb-1:0] count_q, count_d;
  logic          key_valid_q, key_valid_d;

  // The Moore outputs are registered copies of a decode of the next state, so
  // in every cycle they reflect the current state without combinational glitches.
  logic load_key_q,   load_key_d;
  logic load_data_q,  load_data_d;
  logic init_key_q,   init_key_d;
  logic key_exp_en_q, key_exp_en_d;
  logic init_block_q, init_block_d;
  logic round_en_q,   round_en_d;
  logic done_data_q,  done_data_d;
  logic busy_q,       busy_d;

  // Next-state, round counter and key-valid flag.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    key_valid_d = key_valid_q;
    case (state_q)
      S_IDLE: begin
        // A new key always wins over pending data; the data is served on a
        // later visit to IDLE once the new schedule is complete.
        if (newKey) begin
          state_d     = S_KEYLOAD;
          key_valid_d = 1'b0;
        end else if (newData && key_valid_q) begin
          state_d = S_BLKLOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KEYLOAD: begin
        state_d = S_KEYEXP;
        count_d = CNT_KEY0;
      end
      S_KEYEXP: begin
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          state_d     = S_IDLE;
          key_valid_d = 1'b1;
        end else begin
          state_d = S_KEYEXP;
        end
      end
      S_BLKLOAD: begin
        state_d = S_ROUND;
        count_d = CNT_ZERO;
      end
      S_ROUND: begin
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_DONE: begin
        if (readOut) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode of the state the FSM is about to enter.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    load_key_d   = (state_d == S_KEYLOAD);
    init_key_d   = (state_d == S_KEYLOAD);
    key_exp_en_d = (state_d == S_KEYEXP);
    load_data_d  = (state_d == S_BLKLOAD);
    init_block_d = (state_d == S_BLKLOAD);
    round_en_d   = (state_d == S_ROUND);
    done_data_d  = (state_d == S_DONE);
  end

  // State, counter, key flag and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q      <= S_IDLE;
      count_q      <= CNT_ZERO;
      key_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_key_q   <= 1'b0;
      init_key_q   <= 1'b0;
      key_exp_en_q <= 1'b0;
      load_data_q  <= 1'b0;
      init_block_q <= 1'b0;
      round_en_q   <= 1'b0;
      done_data_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      key_valid_q  <= key_valid_d;
      busy_q       <= busy_d;
      load_key_q   <= load_key_d;
      init_key_q   <= init_key_d;
      key_exp_en_q <= key_exp_en_d;
      load_data_q  <= load_data_d;
      init_block_q <= init_block_d;
      round_en_q   <= round_en_d;
      done_data_q  <= done_data_d;
    end
  end

  assign loadKey   = load_key_q;
  assign loadData  = load_data_q;
  assign initKey   = init_key_q;
  assign keyExpEn  = key_exp_en_q;
  assign initBlock = init_block_q;
  assign roundEn   = round_en_q;
  assign count     = count_q;
  assign keyValid  = key_valid_q;
  assign doneData  = done_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simon_round_ctrl
// Self-checking bench for simon_round_ctrl (N=16, M=4, T=32, Cb=5).
// Stimulus pushes per-cycle expected output vectors (tagged with the absolute
// cycle they belong to) into a scoreboard queue; a monitor on the falling edge
// pops the entry for the current cycle and compares.
// -----------------------------------------------------------------------------
module tb_simon_round_ctrl;

  localparam int N  = 16;
  localparam int M  = 4;
  localparam int T  = 32;
  localparam int CB = 5;

  logic          clk = 1'b0;
  logic          nR;
  logic          newKey;
  logic          newData;
  logic          readOut;
  logic          loadKey;
  logic          loadData;
  logic          initKey;
  logic          keyExpEn;
  logic          initBlock;
  logic          roundEn;
  logic [CB-1:0] count;
  logic          keyValid;
  logic          doneData;
  logic          busy;

  simon_round_ctrl #(.N(N), .M(M), .T(T), .Cb(CB)) dut (
    .clk       (clk),
    .nR        (nR),
    .newKey    (newKey),
    .newData   (newData),
    .readOut   (readOut),
    .loadKey   (loadKey),
    .loadData  (loadData),
    .initKey   (initKey),
    .keyExpEn  (keyExpEn),
    .initBlock (initBlock),
    .roundEn   (roundEn),
    .count     (count),
    .keyValid  (keyValid),
    .doneData  (doneData),
    .busy      (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] v;
    bit         chk_cnt;
    logic [4:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Bit order: busy doneData keyValid loadKey loadData initKey initBlock keyExpEn roundEn
  logic [8:0] obs_v;
  assign obs_v = {busy, doneData, keyValid, loadKey, loadData, initKey, initBlock, keyExpEn, roundEn};

  function automatic logic [8:0] mk(input bit bz, input bit dn, input bit kv, input bit lk,
                                    input bit ld, input bit ik, input bit ib, input bit ke,
                                    input bit re);
    return {bz, dn, kv, lk, ld, ik, ib, ke, re};
  endfunction

  logic [8:0] v_zero, v_idle_kv, v_kl, v_ke, v_bl, v_rd, v_dn;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Cycle counter: the cycle number of the state that follows each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compare outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      check_eq("sb_stale", e.cyc, cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      check_eq($sformatf("outs@%0d", cyc), {23'd0, obs_v}, {23'd0, e.v});
      if (e.chk_cnt) begin
        check_eq($sformatf("count@%0d", cyc), {27'd0, count}, {27'd0, e.cnt});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int off, input logic [8:0] v, input bit chk_cnt, input int cnt);
    exp_t e;
    e.cyc     = cyc + off;
    e.v       = v;
    e.chk_cnt = chk_cnt;
    e.cnt     = cnt[4:0];
    sb_q.push_back(e);
  endtask

  // KEYLOAD at off, KEYEXP for T-M cycles with count M..T-1, then IDLE with keyValid.
  task automatic push_key(input int off);
    expect_at(off, v_kl, 1'b0, 0);
    for (int i = 0; i < T - M; i++) expect_at(off + 1 + i, v_ke, 1'b1, M + i);
    expect_at(off + T - M + 1, v_idle_kv, 1'b0, 0);
  endtask

  // BLKLOAD at off, ROUND for T cycles with count 0..T-1, then done_len DONE cycles.
  task automatic push_block(input int off, input int done_len);
    expect_at(off, v_bl, 1'b0, 0);
    for (int i = 0; i < T; i++) expect_at(off + 1 + i, v_rd, 1'b1, i);
    for (int i = 0; i < done_len; i++) expect_at(off + T + 1 + i, v_dn, 1'b0, 0);
  endtask

  initial begin
    v_zero    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_idle_kv = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    v_kl      = mk(1, 0, 0, 1, 0, 1, 0, 0, 0);
    v_ke      = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
    v_bl      = mk(1, 0, 1, 0, 1, 0, 1, 0, 0);
    v_rd      = mk(1, 0, 1, 0, 0, 0, 0, 0, 1);
    v_dn      = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);

    nR = 1'b0; newKey = 1'b0; newData = 1'b0; readOut = 1'b0;
    wait_cyc(1);

    // Reset state, then key load and expansion.
    expect_at(0, v_zero, 1'b1, 0);
    nR = 1'b1; newKey = 1'b1;
    push_key(1);
    wait_cyc(1); newKey = 1'b0;
    wait_cyc(29);

    // Block: load, 32 rounds, DONE held 10 cycles, then readOut.
    newData = 1'b1;
    push_block(1, 10);
    wait_cyc(1); newData = 1'b0;
    wait_cyc(42);
    readOut = 1'b1;
    expect_at(1, v_idle_kv, 1'b0, 0);
    wait_cyc(1); readOut = 1'b0;

    // Key and data together: key first, data after the new schedule is ready.
    newKey = 1'b1; newData = 1'b1;
    push_key(1);
    push_block(31, 1);
    wait_cyc(1); newKey = 1'b0;
    wait_cyc(30); newData = 1'b0;
    wait_cyc(33);
    readOut = 1'b1;
    expect_at(1, v_idle_kv, 1'b0, 0);
    wait_cyc(1); readOut = 1'b0;

    // Reset at round count 15, then data without a key stays unacknowledged.
    newData = 1'b1;
    expect_at(1, v_bl, 1'b0, 0);
    for (int i = 0; i < 16; i++) expect_at(2 + i, v_rd, 1'b1, i);
    wait_cyc(1); newData = 1'b0;
    wait_cyc(16);
    nR = 1'b0; newData = 1'b1;
    for (int i = 1; i <= 52; i++) expect_at(i, v_zero, 1'b1, 0);
    wait_cyc(1); nR = 1'b1;
    wait_cyc(51); newData = 1'b0;

    // New key raised mid-block waits until the block has been read out.
    newKey = 1'b1;
    push_key(1);
    wait_cyc(1); newKey = 1'b0;
    wait_cyc(29);
    newData = 1'b1;
    push_block(1, 5);
    wait_cyc(1); newData = 1'b0;
    wait_cyc(11);
    newKey = 1'b1;
    wait_cyc(26);
    readOut = 1'b1;
    expect_at(1, v_idle_kv, 1'b0, 0);
    push_key(2);
    wait_cyc(1); readOut = 1'b0;
    wait_cyc(1); newKey = 1'b0;
    wait_cyc(29);

    wait_cyc(3);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
